// File: rtl/rng_conditioner_if.sv
//------------------------------------------------------------------------------
// Module   : rng_conditioner_if
// Brief    : Byte output handshake bundle (data/valid/ready) for rng_conditioner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rng_conditioner_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/rng_conditioner.sv
//------------------------------------------------------------------------------
// Module   : rng_conditioner
// Brief    : Ring-oscillator sampler with repetition-count health test,
//            Von Neumann debiasing and byte assembly behind a valid/ready port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rng_conditioner #(
    parameter int SAMPLE_DIV = 4,
    parameter int REP_LIMIT  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              raw_bit,
    input  logic              enable,
    input  logic              clear_fail,
    output logic              health_fail,
    rng_conditioner_if.master out_if
);

    localparam int             PW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [PW-1:0]  DIV_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [7:0]     REP_MAX  = 8'(REP_LIMIT);
    localparam logic [7:0]     REP_PRE  = 8'(REP_LIMIT - 1);
    localparam logic [0:0]     ST_FIRST  = 1'b0;
    localparam logic [0:0]     ST_SECOND = 1'b1;

    logic          sync_meta;
    logic          s_bit;
    logic [PW-1:0] presc;
    logic          strobe;
    logic [7:0]    run_cnt;
    logic          last_sample;
    logic          same;
    logic          fail_set;
    logic          force_first;
    logic [0:0]    state;
    logic [0:0]    state_next;
    logic          pair_bit;
    logic          db_valid;
    logic          db_bit;
    logic [7:0]    asm_byte;
    logic [3:0]    asm_cnt;
    logic          accept;
    logic [7:0]    asm_next;
    logic [3:0]    cnt_next;
    logic          load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta <= 1'b0;
            s_bit     <= 1'b0;
        end else begin
            sync_meta <= raw_bit;
            s_bit     <= sync_meta;
        end
    end

    assign strobe = enable && (presc == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (!enable || strobe) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    // Run counter of zero means "no reference sample yet": next sample starts a run.
    assign same     = (run_cnt != 8'd0) && (s_bit == last_sample);
    assign fail_set = strobe && same && (run_cnt == REP_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            health_fail <= 1'b0;
            run_cnt     <= 8'd0;
            last_sample <= 1'b0;
        end else begin
            if (fail_set) begin
                health_fail <= 1'b1;
            end else if (clear_fail) begin
                health_fail <= 1'b0;
            end
            if (clear_fail && !fail_set) begin
                run_cnt <= 8'd0;
            end else if (strobe) begin
                last_sample <= s_bit;
                if (!same) begin
                    run_cnt <= 8'd1;
                end else if (run_cnt != REP_MAX) begin
                    run_cnt <= run_cnt + 8'd1;
                end
            end
        end
    end

    assign force_first = health_fail || !enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FIRST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (force_first) begin
            state_next = ST_FIRST;
        end else if (strobe) begin
            state_next = (state == ST_FIRST) ? ST_SECOND : ST_FIRST;
        end
    end

    always_comb begin
        db_valid = 1'b0;
        db_bit   = pair_bit;
        if (!force_first && strobe && (state == ST_SECOND) && (s_bit != pair_bit)) begin
            db_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_bit <= 1'b0;
        end else if (strobe && (state == ST_FIRST)) begin
            pair_bit <= s_bit;
        end
    end

    // A full byte (count 8) blocks further bits until the output register takes it.
    assign accept   = db_valid && (asm_cnt != 4'd8);
    assign asm_next = accept ? {db_bit, asm_byte[7:1]} : asm_byte;
    assign cnt_next = asm_cnt + {3'b000, accept};
    assign load     = (cnt_next == 4'd8) && (!out_if.valid || out_if.ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_cnt  <= 4'd0;
            asm_byte <= 8'h00;
        end else if (load || (force_first && (asm_cnt != 4'd8))) begin
            asm_cnt  <= 4'd0;
            asm_byte <= 8'h00;
        end else begin
            asm_cnt  <= cnt_next;
            asm_byte <= asm_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_if.data  <= 8'h00;
            out_if.valid <= 1'b0;
        end else if (load) begin
            out_if.data  <= asm_next;
            out_if.valid <= 1'b1;
        end else if (out_if.valid && out_if.ready) begin
            out_if.valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rng_conditioner.sv
//------------------------------------------------------------------------------
// Module   : tb_rng_conditioner
// Brief    : Scoreboard bench for rng_conditioner (SAMPLE_DIV=1, REP_LIMIT=32).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rng_conditioner;

    localparam int SAMPLE_DIV = 1;
    localparam int REP_LIMIT  = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic raw_bit = 1'b0;
    logic enable = 1'b0;
    logic clear_fail = 1'b0;
    logic health_fail;

    rng_conditioner_if bus ();

    rng_conditioner #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .REP_LIMIT  (REP_LIMIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .raw_bit     (raw_bit),
        .enable      (enable),
        .clear_fail  (clear_fail),
        .health_fail (health_fail),
        .out_if      (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    logic [7:0] exp_q[$];
    bit         seq[$];

    // Reference model state (pairing, assembly, health test)
    bit         m_phase, m_lat, m_last, m_fail;
    int         m_run, m_cnt;
    logic [7:0] m_byte;

    int f_first_done, f_fail_j, f_vrise, f_fail_at;
    bit f_gap;
    bit feed_rdy;
    int feed_pulse_at;

    // Sample stream: a 1 bit becomes pair (1,0), a 0 bit pair (0,1); optional wasted pairs.
    task automatic enc_byte(input logic [7:0] v, input bit filler);
        for (int k = 0; k < 8; k++) begin
            if (filler) begin
                bit f;
                f = ~k[0];
                seq.push_back(f);
                seq.push_back(f);
            end
            seq.push_back(v[k]);
            seq.push_back(~v[k]);
        end
    endtask

    task automatic model_sample(input bit b, input int j, inout int pushes, input int max_push);
        if (!m_fail) begin
            if (!m_phase) begin
                m_lat   = b;
                m_phase = 1'b1;
            end else begin
                m_phase = 1'b0;
                if (m_lat != b) begin
                    m_byte = {m_lat, m_byte[7:1]};
                    m_cnt++;
                    if (m_cnt == 8) begin
                        m_cnt = 0;
                        if (pushes < max_push) begin
                            exp_q.push_back(m_byte);
                            pushes++;
                        end
                        if (f_first_done < 0) f_first_done = j;
                    end
                end
            end
        end else begin
            m_phase = 1'b0;
            m_cnt   = 0;
        end
        if (m_run > 0 && b == m_last) begin
            if (m_run < REP_LIMIT) begin
                m_run++;
                if (m_run == REP_LIMIT && !m_fail) begin
                    m_fail   = 1'b1;
                    f_fail_j = j;
                end
            end
        end else begin
            m_run = 1;
        end
        m_last = b;
    endtask

    // Sample j is driven in iteration j and strobed with enable raised in iteration j+2.
    task automatic feed(input int max_push);
        int pushes = 0;
        bit vprev;
        int n;
        n = seq.size();
        f_first_done = -1; f_fail_j = -1; f_vrise = -1; f_fail_at = -1; f_gap = 1'b0;
        m_phase = 1'b0; m_cnt = 0;
        vprev = bus.valid;
        for (int i = 0; i < n + 3; i++) begin
            @(posedge clk); #1;
            if (i > 0) begin
                if (health_fail && f_fail_at < 0) f_fail_at = i - 1;
                if (bus.valid && !vprev && f_vrise < 0) f_vrise = i - 1;
                if (vprev && !bus.valid) f_gap = 1'b1;
                vprev = bus.valid;
            end
            raw_bit   = (i < n) ? seq[i] : 1'b0;
            enable    = (i >= 2 && i < n + 2);
            bus.ready = (i == feed_pulse_at) ? 1'b1 : feed_rdy;
            if (i >= 2 && i < n + 2) model_sample(seq[i-2], i - 2, pushes, max_push);
        end
        bus.ready = feed_rdy;
        seq.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit         stall_prev = 1'b0;
    logic [7:0] stall_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("stall_stable", int'(bus.data), int'(stall_data));
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) check("xfer_unexpected", int'(bus.data), -1);
                else check("byte", int'(bus.data), int'(exp_q.pop_front()));
            end
            stall_prev = bus.valid && !bus.ready;
            stall_data = bus.data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.ready = 1'b0; feed_rdy = 1'b0; feed_pulse_at = -1;
        m_phase = 0; m_lat = 0; m_last = 0; m_fail = 0; m_run = 0; m_cnt = 0; m_byte = 8'h00;

        idle(3);
        check("rst_data",  int'(bus.data), 8'h00);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_fail",  int'(health_fail), 0);
        rst_n = 1'b1;

        // Straight streams, consumer always ready
        feed_rdy = 1'b1; bus.ready = 1'b1;
        enc_byte(8'hFF, 1'b0); feed(8);
        check("lat_ff", f_vrise, f_first_done + 2);
        idle(3);
        enc_byte(8'h00, 1'b0); feed(8);
        check("lat_00", f_vrise, f_first_done + 2);
        idle(3);
        enc_byte(8'h55, 1'b0); feed(8);
        check("lat_55", f_vrise, f_first_done + 2);
        idle(3);
        enc_byte(8'h55, 1'b1); feed(8);
        check("lat_55_filler", f_vrise, f_first_done + 2);
        idle(3);

        // Backpressure: first byte held, second held full, third discarded
        feed_rdy = 1'b0; bus.ready = 1'b0;
        enc_byte(8'hA3, 1'b0); enc_byte(8'h3C, 1'b0); enc_byte(8'h5A, 1'b0);
        feed(2);
        check("stall_lat", f_vrise, f_first_done + 2);
        idle(4);
        check("stall_valid", int'(bus.valid), 1);
        check("stall_first", int'(bus.data), 8'hA3);
        bus.ready = 1'b1; idle(1);
        bus.ready = 1'b0;
        check("stall_next_valid", int'(bus.valid), 1);
        check("stall_next_data",  int'(bus.data), 8'h3C);
        idle(3);
        bus.ready = 1'b1; feed_rdy = 1'b1;
        idle(3);
        enc_byte(8'hC5, 1'b1); feed(8);
        idle(3);

        // Byte completes in the same cycle as a transfer
        feed_rdy = 1'b0; bus.ready = 1'b0;
        enc_byte(8'h96, 1'b0); feed(8);
        idle(2);
        enc_byte(8'h69, 1'b0); feed_pulse_at = 17; feed(8); feed_pulse_at = -1;
        check("b2b_no_gap", int'(f_gap), 0);
        check("b2b_valid",  int'(bus.valid), 1);
        check("b2b_data",   int'(bus.data), 8'h69);
        feed_rdy = 1'b1; bus.ready = 1'b1;
        idle(3);

        // Repetition-count failure and recovery
        seq.push_back(1'b0); seq.push_back(1'b0);
        for (int k = 0; k < REP_LIMIT; k++) seq.push_back(1'b1);
        enc_byte(8'h0F, 1'b0);
        feed(8);
        check("fail_at",       f_fail_at, f_fail_j + 2);
        check("fail_sticky",   int'(health_fail), 1);
        check("fail_no_valid", f_vrise, -1);
        clear_fail = 1'b1; idle(1);
        clear_fail = 1'b0; m_fail = 1'b0; m_run = 0;
        check("fail_cleared", int'(health_fail), 0);
        enc_byte(8'h0F, 1'b0); feed(8);
        check("resume_lat", f_vrise, f_first_done + 2);
        idle(3);

        // Asynchronous reset mid-handshake and mid-byte
        feed_rdy = 1'b0; bus.ready = 1'b0;
        enc_byte(8'hE7, 1'b0); feed(8);
        enable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            raw_bit = ~raw_bit;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_data",  int'(bus.data), 8'h00);
        check("arst_valid", int'(bus.valid), 0);
        check("arst_fail",  int'(health_fail), 0);
        exp_q.delete();
        enable = 1'b0; raw_bit = 1'b0; m_run = 0; m_fail = 1'b0;
        idle(3);
        check("arst_hold_valid", int'(bus.valid), 0);
        check("arst_hold_data",  int'(bus.data), 8'h00);
        rst_n = 1'b1;
        feed_rdy = 1'b1; bus.ready = 1'b1;
        enc_byte(8'h2D, 1'b0); feed(8);
        check("post_rst_lat", f_vrise, f_first_done + 2);
        idle(3);
        check("sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rng_conditioner.md
RNG_CONDITIONER -- requirements
Module: rng_conditioner

Interface
REQ-001 Parameter SAMPLE_DIV, default 4: clocks between raw-bit samples; legal range 1..256.
REQ-002 Parameter REP_LIMIT, default 32: consecutive identical samples that trip the health test; legal range 2..255.
REQ-003 Port clk, input, 1: single clock; all state on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port raw_bit, input, 1: free-running ring-oscillator output, asynchronous to clk.
REQ-006 Port enable, input, 1: sampling enable.
REQ-007 Port clear_fail, input, 1: clears health_fail.
REQ-008 Port ready, input, 1: consumer accepts data.
REQ-009 Port data, output, 8: conditioned random byte.
REQ-010 Port valid, output, 1: data holds an unconsumed byte.
REQ-011 Port health_fail, output, 1: sticky repetition-count failure flag.

Function
REQ-012 raw_bit SHALL pass through a 2-flop synchronizer; only the second-flop output (s_bit) is used.
REQ-013 Prescaler counts 0..SAMPLE_DIV-1 while enable=1 and emits a sample strobe when it reaches SAMPLE_DIV-1, then wraps to 0; it holds at 0 while enable=0.
REQ-014 On each strobe, s_bit is the sample.
REQ-015 Health test: a run counter SHALL count consecutive equal samples, starting at 1 on a value change.
REQ-016 health_fail SHALL set on the strobe where the run counter reaches REP_LIMIT.
REQ-017 health_fail SHALL stay set until clear_fail=1; clearing resets the run counter to 0.
REQ-018 If set and clear conditions coincide, set wins.
REQ-019 Von Neumann pair FSM has two states, FIRST and SECOND. FIRST latches the sample and goes to SECOND. SECOND compares the new sample with the latched one and always returns to FIRST.
REQ-020 In SECOND: (1,0) emits debiased bit 1; (0,1) emits 0; (0,0) and (1,1) emit nothing.
REQ-021 Assembly: each debiased bit shifts into an 8-bit register, LSB first (first bit ends in bit 0), with a 0..8 bit count.
REQ-022 At count 8, the byte transfers to the output register when valid=0, or when valid&ready in the same cycle; the count returns to 0; valid is 1 the following cycle.
REQ-023 Latency from the strobe producing the 8th bit to valid=1 is 1 clock when the output register is free.
REQ-024 If count=8 and the output register is occupied, the assembled byte is held; further debiased bits are discarded until it transfers.
REQ-025 Handshake: a transfer occurs on valid&ready; data is stable while valid&!ready.
REQ-026 valid clears after a transfer unless a new byte loads in the same cycle, in which case valid stays 1 with the new data.
REQ-027 While health_fail=1, no debiased bits are accepted; the partial byte (count<8) is cleared and the FSM is forced to FIRST. A pending output byte and a held full byte remain deliverable.
REQ-028 enable=0 forces FSM to FIRST and clears a partial byte; the output register and valid are unaffected.
REQ-029 The run counter saturates at REP_LIMIT.

Reset
REQ-030 rst_n=0 SHALL immediately clear data to 0x00, valid to 0, health_fail to 0, all counters to 0, FSM to FIRST, and synchronizer flops to 0.
REQ-031 Reset asserted mid-byte or mid-handshake discards all contents; after release, the first valid requires 16 fresh pair samples.

Verification
REQ-032 Reset: rst_n=0 with arbitrary traffic -> data=0x00, valid=0, health_fail=0 in the same cycle, held until release.
REQ-033 SAMPLE_DIV=1, samples alternating 1,0 for 16 strobes -> data=0xFF, valid=1 one clock after the 16th strobe; samples 0,1 -> data=0x00.
REQ-034 Pairs (1,0),(0,1) repeated x4 -> data=0x55; interleaved (1,1)/(0,0) pairs -> same byte, delayed only.
REQ-035 REP_LIMIT=32, raw held 1 -> health_fail=1 at the 32nd strobe, no new valid; clear_fail pulse -> health_fail=0 and bytes resume.
REQ-036 ready=0, three bytes' worth of bits -> first byte held stable, second held full, third byte's bits discarded. Then ready=1 for 1 cycle -> second byte on data with valid still 1, followed by a normal stream.
REQ-037 Byte completes in the same cycle as valid&ready -> new data loaded, valid stays 1 with no gap.
